// File: rtl/upward_rank_cpt_pkg.sv
// Shared scheduler package for the upward-rank / critical-path block.
// Holds the default parameter constants, the FSM state encoding and a small
// helper used to size task-index registers.
package upward_rank_cpt_pkg;

    localparam int unsigned DefNumTasks      = 10;
    localparam int unsigned DefNumProcessors = 3;
    localparam int unsigned DefDataWidth     = 32;
    localparam int unsigned DefRankWidth     = 16;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StInit  = 3'd1;
    localparam state_t StAvg   = 3'd2;
    localparam state_t StScan  = 3'd3;
    localparam state_t StTrace = 3'd4;
    localparam state_t StDone  = 3'd5;

    // Bits needed to hold an index 0..n-1 (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exec_avg.sv
// Per-task average execution time.
// Combinational: sums the execution times of one task over all processors and
// divides by the (constant) processor count, rounding down.
//
// Ports:
//   w_col  in   NUM_PROCESSORS*DATA_WIDTH  execution time of one task per processor
//   avg    out  DATA_WIDTH                 floor(sum / NUM_PROCESSORS)
module exec_avg
    import upward_rank_cpt_pkg::*;
#(
    parameter int unsigned NUM_PROCESSORS = DefNumProcessors,
    parameter int unsigned DATA_WIDTH     = DefDataWidth
) (
    input  logic [NUM_PROCESSORS*DATA_WIDTH-1:0] w_col,
    output logic [DATA_WIDTH-1:0]                avg
);

    localparam int NP   = int'(NUM_PROCESSORS);
    localparam int DW   = int'(DATA_WIDTH);
    // Extra bits so the sum over all processors cannot overflow.
    localparam int SumW = DW + int'(idx_width(NUM_PROCESSORS)) + 1;

    logic [SumW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int p = 0; p < NP; p++) begin
            sum = sum + SumW'(w_col[p*DW +: DW]);
        end
        // The quotient never exceeds the largest single word, so truncation is exact.
        avg = DW'(sum / SumW'(NP));
    end

endmodule

// File: rtl/upward_rank_cpt.sv
// Upward rank and critical-path-task (CPT) engine for a task DAG.
// Tasks are indexed topologically (edges only i<j). Ranks are computed from the
// last task backwards, one successor examined per cycle; optionally the path
// following each task's best successor is then traced from task 0.
//
// Configuration macro: UPWARD_RANK_CPT_TRACE_EN
//   defined   : TRACE state runs, CPT / cpt_len report the critical path
//   undefined : TRACE skipped, CPT and cpt_len tied to 0
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   start         in   one-cycle run request, sampled only when idle
//   comm_cost_in  in   c(i,j) word i*NUM_TASKS+j, word 0 in the MSBs; 0 = no edge
//   exec_time_in  in   w(p,i) word p*NUM_TASKS+i, word 0 in the MSBs
//   rank_out      out  upward rank per task, word 0 in the MSBs
//   CPT           out  critical-path task indices from word 0 (MSBs), zero-padded
//   cpt_len       out  number of valid CPT words
//   busy          out  run in progress
//   done          out  results valid; held until the next accepted start
module upward_rank_cpt
    import upward_rank_cpt_pkg::*;
#(
    parameter int unsigned NUM_TASKS      = DefNumTasks,
    parameter int unsigned NUM_PROCESSORS = DefNumProcessors,
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned RANK_WIDTH     = DefRankWidth
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [NUM_TASKS*NUM_TASKS*DATA_WIDTH-1:0]      comm_cost_in,
    input  logic [NUM_PROCESSORS*NUM_TASKS*DATA_WIDTH-1:0] exec_time_in,
    output logic [NUM_TASKS*RANK_WIDTH-1:0]               rank_out,
    output logic [NUM_TASKS*DATA_WIDTH-1:0]               CPT,
    output logic [DATA_WIDTH-1:0]                         cpt_len,
    output logic                                          busy,
    output logic                                          done
);

    localparam int N    = int'(NUM_TASKS);
    localparam int NP   = int'(NUM_PROCESSORS);
    localparam int DW   = int'(DATA_WIDTH);
    localparam int RW   = int'(RANK_WIDTH);
    localparam int IdxW = int'(idx_width(NUM_TASKS));
    // Wide enough for avg + c + rank without wrapping before saturation.
    localparam int SumW = ((DW > RW) ? DW : RW) + 2;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [SumW-1:0] RankMax = {{(SumW-RW){1'b0}}, {RW{1'b1}}};

    state_t            state_q, state_d;
    logic [IdxW-1:0]   i_q, i_d;
    logic [IdxW-1:0]   j_q, j_d;
    logic [DW-1:0]     avg_q, avg_d;
    logic [SumW-1:0]   best_q, best_d;
    logic              has_q, has_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              capture;
    logic              clear_run;
    logic              rank_we;
    logic              task_end;
    logic [SumW-1:0]   cand;
    logic [SumW-1:0]   total;
    logic [RW-1:0]     rank_wdata;

    logic [N*N*DW-1:0]  comm_q;
    logic [NP*N*DW-1:0] exec_q;
    logic [NP*DW-1:0]   w_col;
    logic [DW-1:0]      avg_now;
    logic [DW-1:0]      c_word;
    logic [RW-1:0]      rank_q [N];

`ifdef UPWARD_RANK_CPT_TRACE_EN
    logic [IdxW-1:0]   best_j_q, best_j_d;
    logic [IdxW-1:0]   trace_q, trace_d;
    logic [IdxW-1:0]   succ_q [N];
    logic              succ_vld_q [N];
    logic [DW-1:0]     cpt_q [N];
    logic [DW-1:0]     cpt_len_q;
    logic              cpt_we;
`endif

    // Operand selection from the captured matrices.
    always_comb begin
        c_word = '0;
        for (int k = 0; k < N*N; k++) begin
            if (k == int'(i_q) * N + int'(j_q)) begin
                c_word = comm_q[(N*N-1-k)*DW +: DW];
            end
        end
    end

    always_comb begin
        w_col = '0;
        for (int p = 0; p < NP; p++) begin
            for (int t = 0; t < N; t++) begin
                if (t == int'(i_q)) begin
                    w_col[(NP-1-p)*DW +: DW] = exec_q[(NP*N-1-(p*N+t))*DW +: DW];
                end
            end
        end
    end

    exec_avg #(
        .NUM_PROCESSORS (NUM_PROCESSORS),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_exec_avg (
        .w_col (w_col),
        .avg   (avg_now)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        avg_d     = avg_q;
        best_d    = best_q;
        has_d     = has_q;
        busy_d    = busy_q;
        done_d    = done_q;
        capture   = 1'b0;
        clear_run = 1'b0;
        rank_we   = 1'b0;
        task_end  = 1'b0;
        total     = '0;
`ifdef UPWARD_RANK_CPT_TRACE_EN
        best_j_d  = best_j_q;
        trace_d   = trace_q;
        cpt_we    = 1'b0;
`endif
        cand = SumW'(c_word) + SumW'(rank_q[j_q]);

        case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = StInit;
                end
            end
            StInit: begin
                clear_run = 1'b1;
                i_d       = LastIdx;
                state_d   = StAvg;
            end
            StAvg: begin
                avg_d  = avg_now;
                has_d  = 1'b0;
                best_d = '0;
`ifdef UPWARD_RANK_CPT_TRACE_EN
                best_j_d = '0;
`endif
                if (i_q == LastIdx) begin
                    // Last task has no successors: rank is its average alone.
                    rank_we  = 1'b1;
                    total    = SumW'(avg_now);
                    task_end = 1'b1;
                end else begin
                    j_d     = i_q + 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Strict compare while scanning upward keeps the lowest j on ties.
                if ((c_word != '0) && (!has_q || (cand > best_q))) begin
                    has_d  = 1'b1;
                    best_d = cand;
`ifdef UPWARD_RANK_CPT_TRACE_EN
                    best_j_d = j_q;
`endif
                end
                if (j_q == LastIdx) begin
                    rank_we  = 1'b1;
                    total    = SumW'(avg_q) + (has_d ? best_d : '0);
                    task_end = 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
`ifdef UPWARD_RANK_CPT_TRACE_EN
            StTrace: begin
                cpt_we = 1'b1;
                if (succ_vld_q[trace_q]) begin
                    trace_d = succ_q[trace_q];
                end else begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (task_end) begin
            if (i_q == '0) begin
`ifdef UPWARD_RANK_CPT_TRACE_EN
                state_d = StTrace;
                trace_d = '0;
`else
                state_d = StDone;
`endif
            end else begin
                i_d     = i_q - 1'b1;
                state_d = StAvg;
            end
        end

        rank_wdata = (total > RankMax) ? {RW{1'b1}} : total[RW-1:0];
    end

    // Input snapshot; no reset needed, only read after a capture.
    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            comm_q <= comm_cost_in;
            exec_q <= exec_time_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            avg_q   <= '0;
            best_q  <= '0;
            has_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                rank_q[k] <= '0;
            end
`ifdef UPWARD_RANK_CPT_TRACE_EN
            best_j_q  <= '0;
            trace_q   <= '0;
            cpt_len_q <= '0;
            for (int k = 0; k < N; k++) begin
                succ_q[k]     <= '0;
                succ_vld_q[k] <= 1'b0;
                cpt_q[k]      <= '0;
            end
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            avg_q   <= avg_d;
            best_q  <= best_d;
            has_q   <= has_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (clear_run) begin
                for (int k = 0; k < N; k++) begin
                    rank_q[k] <= '0;
                end
            end
            if (rank_we) begin
                rank_q[i_q] <= rank_wdata;
            end
`ifdef UPWARD_RANK_CPT_TRACE_EN
            best_j_q <= best_j_d;
            trace_q  <= trace_d;
            if (clear_run) begin
                cpt_len_q <= '0;
                for (int k = 0; k < N; k++) begin
                    cpt_q[k] <= '0;
                end
            end
            if (rank_we) begin
                succ_q[i_q]     <= best_j_d;
                succ_vld_q[i_q] <= has_d;
            end
            if (cpt_we) begin
                cpt_q[cpt_len_q[IdxW-1:0]] <= DW'(trace_q);
                cpt_len_q                  <= cpt_len_q + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            rank_out[(N-1-k)*RW +: RW] = rank_q[k];
        end
    end

`ifdef UPWARD_RANK_CPT_TRACE_EN
    always_comb begin
        for (int k = 0; k < N; k++) begin
            CPT[(N-1-k)*DW +: DW] = cpt_q[k];
        end
    end
    assign cpt_len = cpt_len_q;
`else
    assign CPT     = '0;
    assign cpt_len = '0;
`endif

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_upward_rank_cpt.sv
module tb_upward_rank_cpt;

    localparam int N   = 10;
    localparam int NP  = 3;
    localparam int DW  = 32;
    localparam int RW  = 16;
    localparam int CW  = N*N*DW;
    localparam int EW  = NP*N*DW;
    localparam int RKW = N*RW;
    localparam int CPW = N*DW;
    localparam int BaseLat = 1 + N + N*(N-1)/2 + 1;
`ifdef UPWARD_RANK_CPT_TRACE_EN
    localparam bit TraceEn = 1'b1;
`else
    localparam bit TraceEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [CW-1:0]  comm_cost_in;
    logic [EW-1:0]  exec_time_in;
    logic [RKW-1:0] rank_out;
    logic [CPW-1:0] CPT;
    logic [DW-1:0]  cpt_len;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    upward_rank_cpt #(
        .NUM_TASKS      (N),
        .NUM_PROCESSORS (NP),
        .DATA_WIDTH     (DW),
        .RANK_WIDTH     (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .comm_cost_in (comm_cost_in),
        .exec_time_in (exec_time_in),
        .rank_out     (rank_out),
        .CPT          (CPT),
        .cpt_len      (cpt_len),
        .busy         (busy),
        .done         (done)
    );

    int checks = 0;
    int errors = 0;

    int unsigned    cmat [N][N];
    int unsigned    wmat [NP][N];
    logic [CW-1:0]  pk_comm;
    logic [EW-1:0]  pk_exec;
    logic [RKW-1:0] m_rank;
    logic [CPW-1:0] m_cpt;
    int             m_len;

    typedef struct {
        string          name;
        logic [CW-1:0]  comm;
        logic [EW-1:0]  exec;
        logic [RKW-1:0] exp_rank;
        logic [CPW-1:0] exp_cpt;
        int             exp_len;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mats();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) cmat[i][j] = 0;
            for (int p = 0; p < NP; p++) wmat[p][i] = 0;
        end
    endtask

    task automatic pack_inputs();
        pk_comm = '0;
        pk_exec = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                pk_comm[(N*N-1-(i*N+j))*DW +: DW] = cmat[i][j];
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < N; i++)
                pk_exec[(NP*N-1-(p*N+i))*DW +: DW] = wmat[p][i];
    endtask

    // Graph edges given with 1-based task numbers.
    task automatic edge_set(input int a, input int b, input int unsigned v);
        cmat[a-1][b-1] = v;
    endtask

    task automatic load_ref_comm();
        edge_set(1, 2, 18); edge_set(1, 3, 12); edge_set(1, 4, 9);  edge_set(1, 5, 11);
        edge_set(1, 6, 14); edge_set(2, 7, 19); edge_set(2, 8, 16); edge_set(3, 7, 23);
        edge_set(4, 8, 27); edge_set(4, 9, 23); edge_set(5, 9, 13); edge_set(6, 8, 15);
        edge_set(7, 10, 17); edge_set(8, 10, 11); edge_set(9, 10, 13);
    endtask

    task automatic load_ref_w();
        int unsigned u1 [N] = '{14, 13, 11, 13, 12, 13, 7, 5, 18, 21};
        int unsigned u2 [N] = '{16, 19, 13, 8, 13, 16, 15, 11, 12, 7};
        int unsigned u3 [N] = '{9, 18, 19, 17, 10, 9, 11, 14, 20, 16};
        for (int i = 0; i < N; i++) begin
            wmat[0][i] = u1[i];
            wmat[1][i] = u2[i];
            wmat[2][i] = u3[i];
        end
    endtask

    // Reference: ranks by reverse topological sweep, path by walking best successors.
    task automatic model();
        longint r [N];
        int     bs [N];
        longint s, mx, v;
        int     t;
        for (int i = N-1; i >= 0; i--) begin
            s = 0;
            for (int p = 0; p < NP; p++) s = s + longint'(wmat[p][i]);
            mx = -1;
            bs[i] = -1;
            for (int j = i+1; j < N; j++) begin
                if (cmat[i][j] != 0) begin
                    v = longint'(cmat[i][j]) + r[j];
                    if (v > mx) begin
                        mx = v;
                        bs[i] = j;
                    end
                end
            end
            r[i] = s / NP + ((mx < 0) ? 0 : mx);
            if (r[i] > 65535) r[i] = 65535;
            m_rank[(N-1-i)*RW +: RW] = RW'(r[i]);
        end
        m_cpt = '0;
        m_len = 0;
        if (TraceEn) begin
            t = 0;
            for (int k = 0; k < N; k++) begin
                m_cpt[(N-1-m_len)*DW +: DW] = DW'(t);
                m_len++;
                if (bs[t] < 0) break;
                t = bs[t];
            end
        end
    endtask

    task automatic run_dut(input string nm, input logic [CW-1:0] comm, input logic [EW-1:0] exec,
                           input logic [RKW-1:0] er, input logic [CPW-1:0] ec, input int elen,
                           input bit dbl);
        int n;
        int elat;
        elat = BaseLat + elen;
        @(negedge clk);
        comm_cost_in = comm;
        exec_time_in = exec;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, " busy_after_accept"}, 512'(busy), 512'(1));
        check({nm, " done_cleared"}, 512'(done), 512'(0));
        // Inputs after the accepting edge must not influence the run.
        comm_cost_in = ~comm;
        exec_time_in = ~exec;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            start = dbl && (n == 5 || n == elat - 1);
        end
        start = 1'b0;
        check({nm, " latency"}, 512'(n), 512'(elat));
        check({nm, " rank_out"}, 512'(rank_out), 512'(er));
        check({nm, " CPT"}, 512'(CPT), 512'(ec));
        check({nm, " cpt_len"}, 512'(cpt_len), 512'(elen));
        check({nm, " busy_at_done"}, 512'(busy), 512'(0));
        repeat (3) @(negedge clk);
        check({nm, " rank_hold"}, 512'(rank_out), 512'(er));
        check({nm, " cpt_hold"}, 512'(CPT), 512'(ec));
        check({nm, " done_hold"}, 512'(done), 512'(1));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        comm_cost_in = '0;
        exec_time_in = '0;

        // Table: reference graph, no edges, tie, saturation.
        clear_mats(); load_ref_comm(); load_ref_w(); pack_inputs();
        vecs[0] = '{"ref", pk_comm, pk_exec,
                    {16'd108, 16'd77, 16'd79, 16'd78, 16'd67, 16'd62, 16'd42, 16'd35, 16'd43,
                     16'd14},
                    TraceEn ? {32'd0, 32'd1, 32'd6, 32'd9, {6{32'd0}}} : '0, TraceEn ? 4 : 0};
        clear_mats(); load_ref_w(); pack_inputs();
        vecs[1] = '{"no_edges", pk_comm, pk_exec,
                    {16'd13, 16'd16, 16'd14, 16'd12, 16'd11, 16'd12, 16'd11, 16'd10, 16'd16,
                     16'd14},
                    TraceEn ? {32'd0, {9{32'd0}}} : '0, TraceEn ? 1 : 0};
        clear_mats();
        cmat[0][1] = 5;
        cmat[0][2] = 5;
        for (int p = 0; p < NP; p++) for (int i = 0; i < N; i++) wmat[p][i] = 3;
        pack_inputs();
        vecs[2] = '{"tie", pk_comm, pk_exec, {16'd11, {9{16'd3}}},
                    TraceEn ? {32'd0, 32'd1, {8{32'd0}}} : '0, TraceEn ? 2 : 0};
        clear_mats(); load_ref_comm();
        for (int p = 0; p < NP; p++) for (int i = 0; i < N; i++) wmat[p][i] = 32'hFFFF_FFFF;
        pack_inputs();
        vecs[3] = '{"saturate", pk_comm, pk_exec, {10{16'hFFFF}},
                    TraceEn ? {32'd0, 32'd1, 32'd6, 32'd9, {6{32'd0}}} : '0, TraceEn ? 4 : 0};

        repeat (3) @(negedge clk);
        check("reset busy", 512'(busy), 512'(0));
        check("reset done", 512'(done), 512'(0));
        check("reset rank_out", 512'(rank_out), 512'(0));
        check("reset CPT", 512'(CPT), 512'(0));
        check("reset cpt_len", 512'(cpt_len), 512'(0));
        reset = 1'b0;

        for (int k = 0; k < 4; k++) begin
            run_dut(vecs[k].name, vecs[k].comm, vecs[k].exec, vecs[k].exp_rank,
                    vecs[k].exp_cpt, vecs[k].exp_len, k == 0);
        end

        // Reset in the middle of the scan abandons the run.
        @(negedge clk);
        comm_cost_in = vecs[0].comm;
        exec_time_in = vecs[0].exec;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset busy", 512'(busy), 512'(0));
        check("midrun_reset done", 512'(done), 512'(0));
        check("midrun_reset rank_out", 512'(rank_out), 512'(0));
        check("midrun_reset CPT", 512'(CPT), 512'(0));
        check("midrun_reset cpt_len", 512'(cpt_len), 512'(0));
        repeat (5) @(negedge clk);
        check("midrun_reset stays_idle", 512'(busy), 512'(0));
        run_dut("ref_after_reset", vecs[0].comm, vecs[0].exec, vecs[0].exp_rank,
                vecs[0].exp_cpt, vecs[0].exp_len, 1'b0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("reset_vs_start busy", 512'(busy), 512'(0));
        repeat (3) @(negedge clk);
        check("reset_vs_start idle", 512'(busy), 512'(0));
        check("reset_vs_start done", 512'(done), 512'(0));

        // Random graphs against the reference model.
        for (int r = 0; r < 8; r++) begin
            clear_mats();
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (j > i) begin
                        if ($urandom_range(0, 99) < 40)
                            cmat[i][j] = (r == 7) ? $urandom : $urandom_range(1, 60);
                    end else begin
                        cmat[i][j] = $urandom;
                    end
                end
                for (int p = 0; p < NP; p++)
                    wmat[p][i] = (r >= 6) ? $urandom : $urandom_range(0, 60);
            end
            model();
            pack_inputs();
            run_dut($sformatf("rand%0d", r), pk_comm, pk_exec, m_rank, m_cpt, m_len, r[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upward_rank_cpt.md
UPWARD_RANK_CPT -- requirements
Module: upward_rank_cpt

Interface
REQ-001 Parameter NUM_TASKS, default 10, task count; tasks are indexed in topological order (edges only i<j).
REQ-002 Parameter NUM_PROCESSORS, default 3, processor count.
REQ-003 Parameter DATA_WIDTH, default 32, width of cost and CPT words.
REQ-004 Parameter RANK_WIDTH, default 16, width of each rank value.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 sync active-high reset.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 comm_cost_in  input  NUM_TASKS*NUM_TASKS*DATA_WIDTH  row-major c(i,j), word i*NUM_TASKS+j, MSB-first packing; 0 = no edge.
REQ-008 exec_time_in  input  NUM_PROCESSORS*NUM_TASKS*DATA_WIDTH  w(p,i), word p*NUM_TASKS+i, MSB-first.
REQ-009 rank_out  output  NUM_TASKS*RANK_WIDTH  upward rank per task, word i.
REQ-010 CPT  output  NUM_TASKS*DATA_WIDTH  critical-path task indices from word 0, zero-padded.
REQ-011 cpt_len  output  DATA_WIDTH  number of valid CPT words.
REQ-012 busy  output  1  high from the cycle after start is accepted until done rises.
REQ-013 done  output  1  level; high from completion until the next accepted start or reset.

Function
REQ-014 Inputs SHALL be captured on the start-accepting edge; later input changes do not affect the run.
REQ-015 FSM states IDLE, INIT, AVG, SCAN, TRACE, DONE; IDLE->INIT on start; INIT->AVG(i=NUM_TASKS-1); AVG->SCAN if i<NUM_TASKS-1 else store; SCAN examines one j per cycle, j=i+1..NUM_TASKS-1; after last j store rank(i), then AVG(i-1) or, after i=0, TRACE; TRACE->DONE->IDLE.
REQ-016 avg(i) SHALL equal floor(sum_p w(p,i) / NUM_PROCESSORS).
REQ-017 rank(i) SHALL equal avg(i) + max over j>i with c(i,j)!=0 of (c(i,j)+rank(j)); avg(i) alone if no successor.
REQ-018 Each per-task sum SHALL saturate at 2^RANK_WIDTH-1.
REQ-019 best_succ(i) SHALL be the lowest j attaining the maximum; entries with j<=i are ignored.
REQ-020 TRACE SHALL start at task 0, write one index per cycle into CPT, follow best_succ, and stop after writing a task with no successor.
REQ-021 Latency from start-accepting edge to done high SHALL be 1 + NUM_TASKS + NUM_TASKS*(NUM_TASKS-1)/2 + cpt_len + 1 cycles.
REQ-022 start while busy or while done is being set SHALL be ignored; start in IDLE with done high SHALL clear done on the next cycle.
REQ-023 rank_out, CPT and cpt_len SHALL hold their values while done is high and change only during a new run.

Reset
REQ-024 Reset SHALL force IDLE from any state, including mid-run, and abandon the run.
REQ-025 After reset: rank_out=0, CPT=0, cpt_len=0, busy=0, done=0.
REQ-026 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-027 Macro UPWARD_RANK_CPT_TRACE_EN: when defined, TRACE and the CPT/cpt_len outputs operate per REQ-020.
REQ-028 Without the macro: TRACE is skipped (SCAN of i=0 -> DONE), CPT and cpt_len are tied to 0, and latency drops by cpt_len.

Structure
REQ-029 The FSM state enum and the default parameter constants SHALL live in the shared scheduler package.
REQ-030 The per-task average SHALL be a sub-module, exec_avg, a combinational sum plus constant divide.

Verification
REQ-031 Reference graph (c: 1->2:18, 1->3:12, 1->4:9, 1->5:11, 1->6:14, 2->7:19, 2->8:16, 3->7:23, 4->8:27, 4->9:23, 5->9:13, 6->8:15, 7->10:17, 8->10:11, 9->10:13; w rows u1 14,13,11,13,12,13,7,5,18,21 / u2 16,19,13,8,13,16,15,11,12,7 / u3 9,18,19,17,10,9,11,14,20,16) -> ranks 108,77,79,78,67,62,42,35,43,14; CPT {0,1,6,9}; cpt_len 4; done exactly 61 cycles after start.
REQ-032 All comm costs 0, any w -> rank(i)=avg(i), CPT {0}, cpt_len 1, latency 58.
REQ-033 Tie: c(0,1)=c(0,2)=5, equal ranks for tasks 1 and 2 -> best_succ(0)=1, CPT word 1 = 1.
REQ-034 w all 0xFFFF_FFFF -> every rank saturates at 0xFFFF, no wrap.
REQ-035 Reset asserted during SCAN -> next cycle busy=0, done=0, all outputs 0; a new start then yields the REQ-031 results.
REQ-036 Second start pulse while busy -> ignored, single run with REQ-031 latency; build without macro -> CPT=0, latency 57.
